// File: rtl/key_conditioner.sv
// ============================================================================
// Module   : key_conditioner
// Brief    : Pushbutton conditioner for active-low, bouncy DE-series KEY
//            inputs. It synchronizes each key, then debounces it, and drives
//            per-key debounced level, press pulse and release pulse outputs.
// Option   : define KEY_CONDITIONER_AUTOREPEAT_EN to make a held key emit
//            repeated key_press pulses (REPEAT_DELAY, then every
//            REPEAT_PERIOD cycles).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_conditioner #(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000
) (
   input  logic              CLOCK_50,
   input  logic              Resetn,
   input  logic [N_KEYS-1:0] KEY,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release
);

   localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   // Accept on the edge that would bring the count to DEBOUNCE_CYCLES.
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_CHK_PRESS = 2'd1,
      ST_HELD      = 2'd2,
      ST_CHK_REL   = 2'd3
   } state_t;

   // Refuse to build with timing parameters that cannot work.
   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("key_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   logic [N_KEYS-1:0] r_sync1;
   logic [N_KEYS-1:0] r_sync2;
   logic [N_KEYS-1:0] w_s;

   // Two-flop synchronizer on the raw active-low keys; reset means released.
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= KEY;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = ~r_sync2;

   for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
      state_t               r_state;
      logic [c_CNT_W-1:0]   r_cnt;
      logic                 r_level;
      logic                 r_press;
      logic                 r_release;
      logic                 w_press_accept;
      logic                 w_rel_accept;
      logic                 w_rep_fire;

      assign w_press_accept = (r_state == ST_CHK_PRESS) && w_s[gi] && (r_cnt >= c_CNT_LAST);
      assign w_rel_accept   = (r_state == ST_CHK_REL) && !w_s[gi] && (r_cnt >= c_CNT_LAST);

`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
      localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

      logic [c_REP_W-1:0] r_rep_cnt;
      logic               r_rep_phase;   // 0: waiting initial delay, 1: periodic
      logic [c_REP_W-1:0] w_rep_next;
      logic [c_REP_W-1:0] w_rep_target;

      assign w_rep_next   = r_rep_cnt + c_REP_W'(1);
      assign w_rep_target = r_rep_phase ? c_REP_W'(REPEAT_PERIOD) : c_REP_W'(REPEAT_DELAY);
      // A repeat never lands on the cycle a release is accepted, so press and
      // release can never coincide.
      assign w_rep_fire   = ((r_state == ST_HELD) || ((r_state == ST_CHK_REL) && !w_rel_accept))
                            && (w_rep_next == w_rep_target);

      // Repeat timer: restarts on each accepted press, runs only while the key is down.
      always_ff @(posedge CLOCK_50 or negedge Resetn) begin
         if (!Resetn) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
         end else if (w_press_accept) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
         end else if (r_state == ST_HELD || r_state == ST_CHK_REL) begin
            if (w_rep_fire) begin
               r_rep_cnt   <= '0;
               r_rep_phase <= 1'b1;
            end else begin
               r_rep_cnt   <= w_rep_next;
            end
         end
      end
`else
      assign w_rep_fire = 1'b0;
`endif

      // Debounce FSM: a change is accepted only after DEBOUNCE_CYCLES agreeing samples.
      always_ff @(posedge CLOCK_50 or negedge Resetn) begin
         if (!Resetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
         end else begin
            r_press   <= w_rep_fire;
            r_release <= 1'b0;
            case (r_state)
               ST_IDLE: begin
                  if (w_s[gi]) begin
                     r_state <= ST_CHK_PRESS;
                     r_cnt   <= c_CNT_ONE;
                  end
               end
               ST_CHK_PRESS: begin
                  if (!w_s[gi]) begin
                     r_state <= ST_IDLE;
                     r_cnt   <= '0;
                  end else if (w_press_accept) begin
                     r_state <= ST_HELD;
                     r_cnt   <= '0;
                     r_level <= 1'b1;
                     r_press <= 1'b1;
                  end else begin
                     r_cnt   <= r_cnt + c_CNT_ONE;
                  end
               end
               ST_HELD: begin
                  if (!w_s[gi]) begin
                     r_state <= ST_CHK_REL;
                     r_cnt   <= c_CNT_ONE;
                  end
               end
               ST_CHK_REL: begin
                  if (w_s[gi]) begin
                     r_state <= ST_HELD;
                     r_cnt   <= '0;
                  end else if (w_rel_accept) begin
                     r_state   <= ST_IDLE;
                     r_cnt     <= '0;
                     r_level   <= 1'b0;
                     r_release <= 1'b1;
                  end else begin
                     r_cnt   <= r_cnt + c_CNT_ONE;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end

      assign key_level[gi]   = r_level;
      assign key_press[gi]   = r_press;
      assign key_release[gi] = r_release;
   end

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// ============================================================================
// Module   : tb_key_conditioner
// Brief    : Self-checking bench for key_conditioner (DEBOUNCE_CYCLES=4,
//            REPEAT_DELAY=10, REPEAT_PERIOD=3). Directed table, a held-key
//            repeat sequence and randomized bouncy keys, each cycle compared
//            against a run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_conditioner;

   localparam int N  = 4;
   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic         CLOCK_50 = 1'b0;
   logic         Resetn;
   logic [N-1:0] KEY;
   logic [N-1:0] key_level;
   logic [N-1:0] key_press;
   logic [N-1:0] key_release;

   int n_tests = 0;
   int n_fail  = 0;

   key_conditioner #(
      .N_KEYS          (N),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .Resetn      (Resetn),
      .KEY         (KEY),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // ---------------- reference model ----------------
   // Two-sample delay line of raw keys, then per key: count consecutive
   // samples disagreeing with the accepted level; D of them flip the level.
   logic [N-1:0] m_h1, m_h2, m_lvl, m_press, m_rel;
   int           m_run [N];
   int           m_held[N];

   function automatic void model_reset();
      m_h1 = '1; m_h2 = '1; m_lvl = '0; m_press = '0; m_rel = '0;
      for (int i = 0; i < N; i++) begin
         m_run[i]  = 0;
         m_held[i] = 0;
      end
   endfunction

   function automatic void model_edge(input logic [N-1:0] k);
      logic [N-1:0] seen;
      seen    = ~m_h2;
      m_h2    = m_h1;
      m_h1    = k;
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < N; i++) begin
         if (seen[i] != m_lvl[i]) m_run[i]++;
         else                     m_run[i] = 0;
         if (m_run[i] == D) begin
            m_run[i] = 0;
            m_lvl[i] = ~m_lvl[i];
            if (m_lvl[i]) begin
               m_press[i] = 1'b1;
               m_held[i]  = 0;
            end else begin
               m_rel[i] = 1'b1;
            end
         end else if (m_lvl[i]) begin
            m_held[i]++;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
            if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RP == 0))
               m_press[i] = 1'b1;
`endif
         end
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // One clock: advance the model with the inputs present at the edge, then compare.
   task automatic tick();
      @(posedge CLOCK_50);
      #1;
      if (!Resetn) model_reset();
      else         model_edge(KEY);
      check("cycle_vs_model", {20'd0, key_level, key_press, key_release}, {20'd0, m_lvl, m_press, m_rel});
      check("press_and_release", {28'd0, key_press & key_release}, 32'd0);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [N-1:0] key;
      logic         rstn;
      int           cycles;
      logic [N-1:0] exp_level;    // level at end of step
      int           exp_npulse;   // cycles with any pulse during step
      int           exp_edge;     // edge index of first pulse (0 = none)
      logic [N-1:0] exp_press;    // press vector at first pulse
      logic [N-1:0] exp_rel;      // release vector at first pulse
   } vec_t;

   vec_t tbl[17];

   task automatic run_step(input int idx, input vec_t v);
      int           npulse, first;
      logic [N-1:0] fp, fr;
      string        nm;
      npulse = 0; first = 0; fp = '0; fr = '0;
      KEY    = v.key;
      Resetn = v.rstn;
      for (int c = 1; c <= v.cycles; c++) begin
         tick();
         if (|(key_press | key_release)) begin
            npulse++;
            if (first == 0) begin
               first = c;
               fp    = key_press;
               fr    = key_release;
            end
         end
      end
      nm = $sformatf("step%0d", idx);
      check({nm, "_level"},  {28'd0, key_level}, {28'd0, v.exp_level});
      check({nm, "_npulse"}, npulse, v.exp_npulse);
      check({nm, "_edge"},   first,  v.exp_edge);
      check({nm, "_press"},  {28'd0, fp}, {28'd0, v.exp_press});
      check({nm, "_rel"},    {28'd0, fr}, {28'd0, v.exp_rel});
   endtask

   initial begin
      int exp_q[$];
      int got_q[$];
      int hold[N];

      //             key    rstn cyc lvl  np edge press rel
      tbl[0]  = '{4'hF, 1'b1, 20, 4'h0, 0, 0, 4'h0, 4'h0};  // idle, nothing happens
      tbl[1]  = '{4'hD, 1'b1,  8, 4'h2, 1, 6, 4'h2, 4'h0};  // KEY[1] press
      tbl[2]  = '{4'hF, 1'b1,  8, 4'h0, 1, 6, 4'h0, 4'h2};  // KEY[1] release
      tbl[3]  = '{4'hB, 1'b1,  3, 4'h0, 0, 0, 4'h0, 4'h0};  // 3-cycle glitch
      tbl[4]  = '{4'hF, 1'b1,  8, 4'h0, 0, 0, 4'h0, 4'h0};  //   rejected
      tbl[5]  = '{4'hB, 1'b1,  1, 4'h0, 0, 0, 4'h0, 4'h0};  // bounce train
      tbl[6]  = '{4'hF, 1'b1,  1, 4'h0, 0, 0, 4'h0, 4'h0};
      tbl[7]  = '{4'hB, 1'b1,  1, 4'h0, 0, 0, 4'h0, 4'h0};
      tbl[8]  = '{4'hF, 1'b1,  1, 4'h0, 0, 0, 4'h0, 4'h0};
      tbl[9]  = '{4'hB, 1'b1,  8, 4'h4, 1, 6, 4'h4, 4'h0};  //   one press, from last bounce
      tbl[10] = '{4'hF, 1'b1,  8, 4'h0, 1, 6, 4'h0, 4'h4};
      tbl[11] = '{4'h0, 1'b1,  8, 4'hF, 1, 6, 4'hF, 4'h0};  // all keys together
      tbl[12] = '{4'hF, 1'b1,  8, 4'h0, 1, 6, 4'h0, 4'hF};
      tbl[13] = '{4'h0, 1'b1,  4, 4'h0, 0, 0, 4'h0, 4'h0};  // mid-debounce...
      tbl[14] = '{4'h0, 1'b0,  2, 4'h0, 0, 0, 4'h0, 4'h0};  //   ...reset aborts
      tbl[15] = '{4'h0, 1'b1,  8, 4'hF, 1, 6, 4'hF, 4'h0};  // held through reset: fresh press
      tbl[16] = '{4'hF, 1'b1,  8, 4'h0, 1, 6, 4'h0, 4'hF};

      // Reset with keys released: outputs must be 0 immediately.
      model_reset();
      Resetn = 1'b0;
      KEY    = 4'hF;
      #2;
      check("reset_async_outputs", {20'd0, key_level, key_press, key_release}, 32'd0);
      tick();
      tick();

      for (int i = 0; i < 17; i++) run_step(i, tbl[i]);

      // Held key: single press, or auto-repeat at accept+10, +13, +16 ...
      exp_q.push_back(6);
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
      for (int e = 6 + RD; e <= 36; e += RP) exp_q.push_back(e);
`endif
      KEY = 4'hE;
      for (int c = 1; c <= 36; c++) begin
         tick();
         if (key_press[0]) got_q.push_back(c);
      end
      check("repeat_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("repeat_edge%0d", i), got_q[i], exp_q[i]);
      KEY = 4'hF;
      for (int c = 0; c < 10; c++) tick();

      // Randomized bouncy keys with occasional resets, checked against the model.
      for (int i = 0; i < N; i++) hold[i] = 0;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (hold[i] == 0) begin
               KEY[i]  = ($urandom_range(0, 1) == 1) ? ~KEY[i] : KEY[i];
               hold[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 40)
                                                       : $urandom_range(1, 8);
            end else begin
               hold[i]--;
            end
         end
         Resetn = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
